// File: rtl/stld_fwd_cache_pkg.sv
// Shared configuration and types for the store-to-load forwarding cache.
// Holds the LSU configuration constants, the memory width encoding and the table entry layout.
package stld_fwd_cache_pkg;

    localparam int unsigned STBUFF_DEPTH           = 16;
    localparam logic [63:0] MMAP_MASK              = 64'hffff_ffff_e000_0000;
    localparam bit          LEN5_STORE_LOAD_FWD_EN = 1'b1;

    localparam int unsigned STLD_IDX_W    = $clog2(STBUFF_DEPTH);
    localparam int unsigned STLD_SB_IDX_W = $clog2(STBUFF_DEPTH);
    // Tag keeps the bits above the index plus the byte offset, so it is 64 - IDX_W bits wide
    localparam int unsigned STLD_TAG_W    = 64 - STLD_IDX_W;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_width_t;

    typedef struct packed {
        logic                     valid;
        logic [STLD_TAG_W-1:0]    tag;
        mem_width_t               width;
        logic [STLD_SB_IDX_W-1:0] sb_idx;
    } stld_fwd_entry_t;

endpackage

// File: rtl/stld_fwd_cache.sv
// Direct-mapped table recording which store-buffer slot holds the youngest store per doubleword.
// Lookups are combinational on pre-edge state; updates, retires and flushes land at the clock edge.
module stld_fwd_cache
    import stld_fwd_cache_pkg::*;
#(
    parameter int unsigned DEPTH    = STBUFF_DEPTH,
    parameter int unsigned SB_IDX_W = $clog2(DEPTH),
    parameter logic [63:0] MASK     = MMAP_MASK
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                st_upd_valid_i,
    input  logic [63:0]         st_upd_addr_i,
    input  logic [1:0]          st_upd_width_i,
    input  logic [SB_IDX_W-1:0] st_upd_idx_i,
    input  logic                st_ret_valid_i,
    input  logic [SB_IDX_W-1:0] st_ret_idx_i,
    input  logic                ld_valid_i,
    input  logic [63:0]         ld_addr_i,
    input  logic [1:0]          ld_width_i,
    output logic                ld_hit_o,
    output logic [SB_IDX_W-1:0] ld_idx_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned TAG_W = 64 - IDX_W;

    stld_fwd_entry_t table_q [DEPTH];

    logic             upd_en;
    logic [IDX_W-1:0] upd_slot;
    logic [TAG_W-1:0] upd_tag;

    logic             lk_mmap;
    logic [IDX_W-1:0] lk_slot;
    logic [TAG_W-1:0] lk_tag;
    stld_fwd_entry_t  lk_entry;

    assign upd_en   = st_upd_valid_i && ((st_upd_addr_i & MASK) == '0);
    assign upd_slot = st_upd_addr_i[IDX_W+2:3];
    assign upd_tag  = {st_upd_addr_i[63:IDX_W+3], st_upd_addr_i[2:0]};

    // Only valid bits are reset; payload is don't-care while the entry is invalid
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                table_q[i].valid <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (flush_i) begin
                    table_q[i].valid <= 1'b0;
                end else if (upd_en && (upd_slot == IDX_W'(i))) begin
                    // Update outranks a same-cycle retire so the younger store survives
                    table_q[i].valid  <= 1'b1;
                    table_q[i].tag    <= upd_tag;
                    table_q[i].width  <= mem_width_t'(st_upd_width_i);
                    table_q[i].sb_idx <= st_upd_idx_i;
                end else if (st_ret_valid_i && (table_q[i].sb_idx == st_ret_idx_i)) begin
                    table_q[i].valid <= 1'b0;
                end
            end
        end
    end

    assign lk_mmap  = (ld_addr_i & MASK) != '0;
    assign lk_slot  = ld_addr_i[IDX_W+2:3];
    assign lk_tag   = {ld_addr_i[63:IDX_W+3], ld_addr_i[2:0]};
    assign lk_entry = table_q[lk_slot];

    always_comb begin
        ld_hit_o = 1'b0;
        ld_idx_o = '0;
        if (ld_valid_i && lk_entry.valid && !lk_mmap && (lk_entry.tag == lk_tag)
            && (ld_width_i <= 2'(lk_entry.width))) begin
            ld_hit_o = 1'b1;
            ld_idx_o = lk_entry.sb_idx;
        end
    end

endmodule

// File: tb/tb_stld_fwd_cache.sv
// Self-checking bench for stld_fwd_cache: directed scenarios plus random traffic against
// an address-level reference model (full-address match, youngest store per doubleword slot).
module tb_stld_fwd_cache;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        st_upd_valid_i;
    logic [63:0] st_upd_addr_i;
    logic [1:0]  st_upd_width_i;
    logic [3:0]  st_upd_idx_i;
    logic        st_ret_valid_i;
    logic [3:0]  st_ret_idx_i;
    logic        ld_valid_i;
    logic [63:0] ld_addr_i;
    logic [1:0]  ld_width_i;
    logic        ld_hit_o;
    logic [3:0]  ld_idx_o;

    int checks = 0;
    int errors = 0;

    // Reference model: per doubleword slot, the full address of the youngest recorded store
    bit          m_valid [16];
    logic [63:0] m_addr  [16];
    logic [1:0]  m_width [16];
    logic [3:0]  m_idx   [16];

    stld_fwd_cache #(
        .DEPTH    (16),
        .SB_IDX_W (4),
        .MASK     (64'hffff_ffff_e000_0000)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .st_upd_valid_i (st_upd_valid_i),
        .st_upd_addr_i  (st_upd_addr_i),
        .st_upd_width_i (st_upd_width_i),
        .st_upd_idx_i   (st_upd_idx_i),
        .st_ret_valid_i (st_ret_valid_i),
        .st_ret_idx_i   (st_ret_idx_i),
        .ld_valid_i     (ld_valid_i),
        .ld_addr_i      (ld_addr_i),
        .ld_width_i     (ld_width_i),
        .ld_hit_o       (ld_hit_o),
        .ld_idx_o       (ld_idx_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic bit is_mmap(input logic [63:0] a);
        return (a & 64'hffff_ffff_e000_0000) != 64'd0;
    endfunction

    function automatic int slot_of(input logic [63:0] a);
        return int'((a / 8) % 16);
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
    endfunction

    function automatic void model_lookup(input logic [63:0] a, input logic [1:0] w,
                                         output logic eh, output logic [3:0] ei);
        int s;
        s  = slot_of(a);
        eh = 1'b0;
        ei = 4'd0;
        if (m_valid[s] && m_addr[s] == a && w <= m_width[s] && !is_mmap(a)) begin
            eh = 1'b1;
            ei = m_idx[s];
        end
    endfunction

    // Applies the currently driven store/retire/flush inputs to the model (edge semantics)
    function automatic void model_commit();
        int s;
        if (flush_i) begin
            model_clear();
        end else begin
            if (st_ret_valid_i)
                for (int k = 0; k < 16; k++)
                    if (m_valid[k] && m_idx[k] == st_ret_idx_i) m_valid[k] = 1'b0;
            if (st_upd_valid_i && !is_mmap(st_upd_addr_i)) begin
                s          = slot_of(st_upd_addr_i);
                m_valid[s] = 1'b1;
                m_addr[s]  = st_upd_addr_i;
                m_width[s] = st_upd_width_i;
                m_idx[s]   = st_upd_idx_i;
            end
        end
    endfunction

    task automatic idle_inputs();
        flush_i        = 1'b0;
        st_upd_valid_i = 1'b0;
        st_upd_addr_i  = 64'd0;
        st_upd_width_i = 2'd0;
        st_upd_idx_i   = 4'd0;
        st_ret_valid_i = 1'b0;
        st_ret_idx_i   = 4'd0;
        ld_valid_i     = 1'b0;
        ld_addr_i      = 64'd0;
        ld_width_i     = 2'd0;
    endtask

    task automatic cyc();
        model_commit();
        @(posedge clk_i);
        #1;
        idle_inputs();
    endtask

    task automatic upd(input logic [63:0] a, input logic [1:0] w, input logic [3:0] idx);
        st_upd_valid_i = 1'b1;
        st_upd_addr_i  = a;
        st_upd_width_i = w;
        st_upd_idx_i   = idx;
    endtask

    task automatic ret(input logic [3:0] idx);
        st_ret_valid_i = 1'b1;
        st_ret_idx_i   = idx;
    endtask

    task automatic probe(input logic [63:0] a, input logic [1:0] w);
        ld_valid_i = 1'b1;
        ld_addr_i  = a;
        ld_width_i = w;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_inputs();
        model_clear();
        ld_valid_i = 1'b1;
        ld_addr_i  = 64'h1000;
        ld_width_i = 2'd3;
        #3;
        checks++;
        if (ld_hit_o !== 1'b0 || ld_idx_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_in_reset: hit=%0b idx=%0d expected hit=0 idx=0", ld_hit_o, ld_idx_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        idle_inputs();
        probe(64'h1000, 2'd3);
        checks++;
        if (ld_hit_o !== 1'b0 || ld_idx_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_lookup: hit=%0b idx=%0d expected hit=0 idx=0", ld_hit_o, ld_idx_o);
        end
        cyc();
    endtask

    task automatic test_basic();
        upd(64'h1008, 2'd2, 4'd5);
        probe(64'h1008, 2'd2);
        checks++;
        if (ld_hit_o !== 1'b0) begin
            errors++;
            $display("FAIL no_bypass: hit=%0b expected hit=0", ld_hit_o);
        end
        cyc();
        probe(64'h1008, 2'd2);
        checks++;
        if (ld_hit_o !== 1'b1 || ld_idx_o !== 4'd5) begin
            errors++;
            $display("FAIL basic_hit: hit=%0b idx=%0d expected hit=1 idx=5", ld_hit_o, ld_idx_o);
        end
        cyc();
        probe(64'h1008, 2'd1);
        checks++;
        if (ld_hit_o !== 1'b1 || ld_idx_o !== 4'd5) begin
            errors++;
            $display("FAIL narrow_hit: hit=%0b idx=%0d expected hit=1 idx=5", ld_hit_o, ld_idx_o);
        end
        cyc();
        probe(64'h1008, 2'd3);
        checks++;
        if (ld_hit_o !== 1'b0 || ld_idx_o !== 4'd0) begin
            errors++;
            $display("FAIL width_miss: hit=%0b idx=%0d expected hit=0 idx=0", ld_hit_o, ld_idx_o);
        end
        cyc();
        probe(64'h100C, 2'd2);
        checks++;
        if (ld_hit_o !== 1'b0 || ld_idx_o !== 4'd0) begin
            errors++;
            $display("FAIL offset_miss: hit=%0b idx=%0d expected hit=0 idx=0", ld_hit_o, ld_idx_o);
        end
        cyc();
    endtask

    task automatic test_overwrite_retire();
        upd(64'h1008, 2'd3, 4'd5);
        cyc();
        upd(64'h1008, 2'd3, 4'd9);
        cyc();
        ret(4'd5);
        cyc();
        probe(64'h1008, 2'd3);
        checks++;
        if (ld_hit_o !== 1'b1 || ld_idx_o !== 4'd9) begin
            errors++;
            $display("FAIL stale_retire: hit=%0b idx=%0d expected hit=1 idx=9", ld_hit_o, ld_idx_o);
        end
        cyc();
        ret(4'd9);
        cyc();
        probe(64'h1008, 2'd3);
        checks++;
        if (ld_hit_o !== 1'b0) begin
            errors++;
            $display("FAIL retire_miss: hit=%0b expected hit=0", ld_hit_o);
        end
        cyc();
    endtask

    task automatic test_upd_ret_same_cycle();
        upd(64'h2000, 2'd2, 4'd3);
        cyc();
        upd(64'h2000, 2'd3, 4'd3);
        ret(4'd3);
        probe(64'h2000, 2'd3);
        checks++;
        if (ld_hit_o !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_pre: hit=%0b expected hit=0", ld_hit_o);
        end
        cyc();
        probe(64'h2000, 2'd3);
        checks++;
        if (ld_hit_o !== 1'b1 || ld_idx_o !== 4'd3) begin
            errors++;
            $display("FAIL upd_beats_ret: hit=%0b idx=%0d expected hit=1 idx=3", ld_hit_o, ld_idx_o);
        end
        cyc();
    endtask

    task automatic test_mmap();
        upd(64'h3000, 2'd3, 4'd7);
        cyc();
        upd(64'h2000_0000, 2'd3, 4'd2);
        cyc();
        probe(64'h2000_0000, 2'd3);
        checks++;
        if (ld_hit_o !== 1'b0 || ld_idx_o !== 4'd0) begin
            errors++;
            $display("FAIL mmap_miss: hit=%0b idx=%0d expected hit=0 idx=0", ld_hit_o, ld_idx_o);
        end
        cyc();
        probe(64'h3000, 2'd3);
        checks++;
        if (ld_hit_o !== 1'b1 || ld_idx_o !== 4'd7) begin
            errors++;
            $display("FAIL mmap_no_clobber: hit=%0b idx=%0d expected hit=1 idx=7", ld_hit_o, ld_idx_o);
        end
        cyc();
        upd(64'h1FFF_FFF8, 2'd3, 4'd4);
        cyc();
        probe(64'h1FFF_FFF8, 2'd3);
        checks++;
        if (ld_hit_o !== 1'b1 || ld_idx_o !== 4'd4) begin
            errors++;
            $display("FAIL below_mmap_hit: hit=%0b idx=%0d expected hit=1 idx=4", ld_hit_o, ld_idx_o);
        end
        cyc();
    endtask

    task automatic test_flush();
        logic [63:0] a;
        for (int i = 0; i < 16; i++) begin
            upd(64'h4000 + 64'(i) * 8, 2'd3, 4'(i));
            cyc();
        end
        probe(64'h4078, 2'd3);
        checks++;
        if (ld_hit_o !== 1'b1 || ld_idx_o !== 4'd15) begin
            errors++;
            $display("FAIL fill_hit: hit=%0b idx=%0d expected hit=1 idx=15", ld_hit_o, ld_idx_o);
        end
        cyc();
        flush_i = 1'b1;
        upd(64'h4000, 2'd3, 4'd1);
        probe(64'h4008, 2'd3);
        checks++;
        if (ld_hit_o !== 1'b1 || ld_idx_o !== 4'd1) begin
            errors++;
            $display("FAIL flush_cycle_old_state: hit=%0b idx=%0d expected hit=1 idx=1", ld_hit_o, ld_idx_o);
        end
        cyc();
        for (int i = 0; i < 16; i++) begin
            a = 64'h4000 + 64'(i) * 8;
            probe(a, 2'd0);
            checks++;
            if (ld_hit_o !== 1'b0) begin
                errors++;
                $display("FAIL flush_miss[%0d]: hit=%0b idx=%0d expected hit=0", i, ld_hit_o, ld_idx_o);
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        upd(64'h5000, 2'd3, 4'd6);
        cyc();
        probe(64'h5000, 2'd3);
        checks++;
        if (ld_hit_o !== 1'b1 || ld_idx_o !== 4'd6) begin
            errors++;
            $display("FAIL pre_reset_hit: hit=%0b idx=%0d expected hit=1 idx=6", ld_hit_o, ld_idx_o);
        end
        #1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (ld_hit_o !== 1'b0 || ld_idx_o !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: hit=%0b idx=%0d expected hit=0 idx=0", ld_hit_o, ld_idx_o);
        end
        model_clear();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        idle_inputs();
        probe(64'h5000, 2'd3);
        checks++;
        if (ld_hit_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_miss: hit=%0b expected hit=0", ld_hit_o);
        end
        cyc();
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        if ($urandom_range(0, 9) == 0) begin
            a = 64'h2000_0000 + 64'($urandom_range(0, 3)) * 8;
        end else begin
            a = 64'h6000 + 64'($urandom_range(0, 23)) * 8;
            if ($urandom_range(0, 3) == 0) a = a + 64'($urandom_range(0, 7));
        end
        return a;
    endfunction

    task automatic test_random();
        logic        eh;
        logic [3:0]  ei;
        logic [63:0] a;
        logic [1:0]  w;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) != 0)
                upd(rand_addr(), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0)
                ret(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 49) == 0)
                flush_i = 1'b1;
            a = rand_addr();
            w = 2'($urandom_range(0, 3));
            probe(a, w);
            model_lookup(a, w, eh, ei);
            checks++;
            if (ld_hit_o !== eh || ld_idx_o !== ei) begin
                errors++;
                $display("FAIL random[%0d] addr=%h w=%0d: hit=%0b idx=%0d expected hit=%0b idx=%0d",
                         n, a, w, ld_hit_o, ld_idx_o, eh, ei);
            end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overwrite_retire();
        test_upd_ret_same_cycle();
        test_mmap();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
